// File: rtl/iomem_if.sv
// PicoSoC iomem bus bundle: request, strobes, address, data and one-cycle ack.
// Ports: master drives valid/wstrb/addr/wdata; slave drives ready/rdata.
interface iomem_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid,
        output iomem_wstrb,
        output iomem_addr,
        output iomem_wdata,
        input  iomem_ready,
        input  iomem_rdata
    );

    modport slave (
        input  iomem_valid,
        input  iomem_wstrb,
        input  iomem_addr,
        input  iomem_wdata,
        output iomem_ready,
        output iomem_rdata
    );
endinterface

// File: rtl/iomem_gpio_ctrl.sv
// GPIO peripheral on the iomem bus: OUT/DIR/IN/IRQ_EN/IRQ_STATUS registers,
// synchronised inputs, primed rising-edge capture and a registered level irq.
// Ports: clk_bufg, resetn (sync, active-low), bus (iomem_if.slave),
// gpio_in (async pins), gpio_out (OUT), gpio_oe (DIR), irq.
// Optional: define GPIO_TOGGLE_EN to map the write-only TOGGLE register at 0x14.
module iomem_gpio_ctrl #(
    parameter int         WIDTH       = 8,
    parameter logic [7:0] BASE_ADDR   = 8'h03,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk_bufg,
    input  logic             resetn,
    iomem_if.slave           bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam logic [2:0] PRIME_N = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] en_q;
    logic [WIDTH-1:0] st_q;
    logic [2:0]       prime_cnt;

    logic             primed;
    logic             sel;
    logic             wr;
    logic [5:0]       off;
    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] s_last;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] st_next;
    logic [WIDTH-1:0] rd_val;
    logic             hit_out;
    logic             hit_dir;
    logic             hit_en;
    logic             hit_st;
    logic             hit_tgl;
    logic             unused_bits;

    assign sel = bus.iomem_valid && !bus.iomem_ready
              && (bus.iomem_addr[31:24] == BASE_ADDR);
    assign wr  = |bus.iomem_wstrb;
    assign off = bus.iomem_addr[7:2];

    assign lane_mask = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                        {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
    assign wmask = lane_mask[WIDTH-1:0];
    assign wbits = bus.iomem_wdata[WIDTH-1:0] & wmask;

    assign hit_out = sel && wr && (off == 6'h00);
    assign hit_dir = sel && wr && (off == 6'h01);
    assign hit_en  = sel && wr && (off == 6'h03);
    assign hit_st  = sel && wr && (off == 6'h04);
`ifdef GPIO_TOGGLE_EN
    assign hit_tgl = sel && wr && (off == 6'h05);
`else
    assign hit_tgl = 1'b0;
`endif

    // Priming masks the spurious edge a pin already high at reset would
    // produce while the synchroniser fills.
    assign primed  = (prime_cnt == PRIME_N);
    assign s_last  = sync_q[SYNC_STAGES-1];
    assign rise    = s_last & ~prev_q & {WIDTH{primed}};
    assign w1c     = hit_st ? wbits : '0;
    assign st_next = (st_q & ~w1c) | rise;

    assign unused_bits = ^{bus.iomem_addr[23:8], bus.iomem_addr[1:0],
                           bus.iomem_wdata};

    always_comb begin
        rd_val = '0;
        case (off)
            6'h00:   rd_val = gpio_out;
            6'h01:   rd_val = gpio_oe;
            6'h02:   rd_val = s_last;
            6'h03:   rd_val = en_q;
            6'h04:   rd_val = st_q;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_bufg) begin
        if (!resetn) begin
            sync_q          <= '0;
            prev_q          <= '0;
            prime_cnt       <= '0;
            gpio_out        <= '0;
            gpio_oe         <= '0;
            en_q            <= '0;
            st_q            <= '0;
            irq             <= 1'b0;
            bus.iomem_ready <= 1'b0;
            bus.iomem_rdata <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            prev_q <= s_last;
            if (!primed) prime_cnt <= prime_cnt + 3'd1;

            st_q <= st_next;
            // irq trails the status/enable registers by one edge.
            irq  <= |(st_q & en_q);

            bus.iomem_ready <= sel;
            bus.iomem_rdata <= (sel && !wr) ? 32'(rd_val) : '0;

            if (hit_out) gpio_out <= (gpio_out & ~wmask) | wbits;
            else if (hit_tgl) gpio_out <= gpio_out ^ wbits;
            if (hit_dir) gpio_oe <= (gpio_oe & ~wmask) | wbits;
            if (hit_en)  en_q    <= (en_q & ~wmask) | wbits;
        end
    end
endmodule

// File: tb/tb_iomem_gpio_ctrl.sv
// Scoreboard bench for iomem_gpio_ctrl: directed scenarios then random
// bus/pin traffic against a register-level reference model.
module tb_iomem_gpio_ctrl;
    localparam int         W    = 8;
    localparam int         S    = 2;
    localparam logic [7:0] BASE = 8'h03;
    localparam logic [31:0] WMASK = 32'((64'd1 << W) - 1);

    logic         clk_bufg = 1'b0;
    logic         resetn   = 1'b0;
    logic [W-1:0] gpio_in;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;

    iomem_if bus ();

    iomem_gpio_ctrl #(.WIDTH(W), .BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
        .clk_bufg (clk_bufg),
        .resetn   (resetn),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk_bufg = ~clk_bufg;

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_out, m_dir, m_in, m_en, m_st;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match one queued access.
    always @(negedge clk_bufg) begin
        if (resetn && bus.iomem_ready === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ready: got ready=1 expected no access pending");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.chk) chk("rdata", bus.iomem_rdata, e.data);
            end
        end
    end

    function automatic logic [31:0] lanes(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}} & WMASK;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:24] != BASE) return 32'h0;
        case (a[7:0] & 8'hFC)
            8'h00:   return m_out;
            8'h04:   return m_dir;
            8'h08:   return m_in;
            8'h0C:   return m_en;
            8'h10:   return m_st;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d);
        logic [31:0] m;
        m = lanes(s);
        case (a[7:0] & 8'hFC)
            8'h00: m_out = (m_out & ~m) | (d & m);
            8'h04: m_dir = (m_dir & ~m) | (d & m);
            8'h0C: m_en  = (m_en & ~m) | (d & m);
            8'h10: m_st  = m_st & ~(d & m);
`ifdef GPIO_TOGGLE_EN
            8'h14: m_out = m_out ^ (d & m);
`endif
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the ack cycle.
    task automatic bus_acc(input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = a;
        bus.iomem_wstrb = s;
        bus.iomem_wdata = d;
        @(posedge clk_bufg);
        @(negedge clk_bufg);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        @(negedge clk_bufg);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
        q.push_back('{chk: 1'b0, data: 32'h0});
        model_write(a, s, d);
        bus_acc(a, s, d);
        chk("gpio_out", 32'(gpio_out), m_out);
        chk("gpio_oe", 32'(gpio_oe), m_dir);
        chk("irq_after_wr", 32'(irq), 32'(|(m_st & m_en)));
    endtask

    task automatic do_read(input logic [31:0] a);
        q.push_back('{chk: 1'b1, data: model_read(a)});
        bus_acc(a, 4'h0, $urandom);
        chk("irq_after_rd", 32'(irq), 32'(|(m_st & m_en)));
    endtask

    task automatic pins(input logic [W-1:0] v);
        logic [31:0] nv;
        nv = 32'(v);
        gpio_in = v;
        repeat (S + 2) @(negedge clk_bufg);
        m_st = m_st | (nv & ~m_in);
        m_in = nv;
        chk("irq_after_pins", 32'(irq), 32'(|(m_st & m_en)));
    endtask

    function automatic logic [31:0] ra(input logic [7:0] o);
        return {BASE, 16'h0000, o};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] offs [8];
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'hFC};

        gpio_in         = '1;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wdata = 32'h0;
        resetn          = 1'b0;
        repeat (3) @(negedge clk_bufg);
        chk("rst_ready", 32'(bus.iomem_ready), 32'h0);
        chk("rst_rdata", bus.iomem_rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_out", 32'(gpio_out), 32'h0);
        chk("rst_oe", 32'(gpio_oe), 32'h0);

        resetn = 1'b1;
        m_out = 0; m_dir = 0; m_en = 0; m_st = 0; m_in = 32'hFF;
        repeat (10) @(negedge clk_bufg);
        chk("primed_irq", 32'(irq), 32'h0);
        do_read(ra(8'h08));
        do_read(ra(8'h10));

        do_write(ra(8'h00), 4'b0001, 32'h0000_00A5);
        do_read(ra(8'h00));

        do_write(ra(8'h04), 4'b0010, 32'h0000_005A);
        chk("dir_lane1", 32'(gpio_oe), 32'h0);
        do_write(ra(8'h04), 4'b0001, 32'h0000_005A);
        chk("dir_lane0", 32'(gpio_oe), 32'h5A);

        do_write(ra(8'h0C), 4'b1111, 32'h1);
        pins(8'h00);
        gpio_in = 8'h01;
        repeat (S + 1) @(negedge clk_bufg);
        chk("irq_early", 32'(irq), 32'h0);
        @(negedge clk_bufg);
        chk("irq_edge", 32'(irq), 32'h1);
        m_st = m_st | 32'h1;
        m_in = 32'h1;
        do_read(ra(8'h10));
        do_write(ra(8'h10), 4'b0001, 32'h1);
        chk("w1c_irq", 32'(irq), 32'h0);

        // New edge lands on the same edge as the W1C of that bit.
        pins(8'h00);
        gpio_in = 8'h01;
        repeat (S) @(negedge clk_bufg);
        q.push_back('{chk: 1'b0, data: 32'h0});
        bus_acc(ra(8'h10), 4'b0001, 32'h1);
        m_st = 32'h1;
        m_in = 32'h1;
        do_read(ra(8'h10));
        do_write(ra(8'h10), 4'b1111, 32'hFF);

        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = 32'h0400_0000;
        bus.iomem_wstrb = 4'b1111;
        bus.iomem_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_bufg);
            chk("nomatch_ready", 32'(bus.iomem_ready), 32'h0);
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        @(negedge clk_bufg);
        chk("nomatch_out", 32'(gpio_out), m_out);
        do_read(ra(8'h00));
        do_read(ra(8'h20));
        do_write(ra(8'h20), 4'b1111, 32'hFFFF_FFFF);

        do_write(ra(8'h00), 4'b0001, 32'hF0);
        do_write(ra(8'h14), 4'b0001, 32'hFF);
`ifdef GPIO_TOGGLE_EN
        chk("toggle_out", 32'(gpio_out), 32'h0F);
`else
        chk("toggle_out", 32'(gpio_out), 32'hF0);
`endif
        do_read(ra(8'h14));

        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            logic [31:0] a;
            logic [3:0]  s;
            r = $urandom_range(0, 9);
            a = {BASE, 16'($urandom), offs[$urandom_range(0, 7)]};
            a[1:0] = 2'($urandom);
            s = 4'($urandom);
            if (r < 2) pins(W'($urandom));
            else if (r < 6) do_read(a);
            else if (s == 4'h0) do_read(a);
            else do_write(a, s, $urandom);
        end

        repeat (3) @(negedge clk_bufg);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_ready: got %0d unacknowledged expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
